// File: rtl/stump_mem_arbiter.sv
// Shares the single Stump memory port between the CPU and a DMA/debug requester,
// with programmable wait states and DMA starvation protection.
// Optional grant statistics counters are built when STUMP_ARB_STATS_EN is defined.
module stump_mem_arbiter #(
  parameter int WAIT_STATES  = 1,
  parameter int STARVE_LIMIT = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req,
  input  logic        cpu_wen,
  input  logic [15:0] cpu_addr,
  input  logic [15:0] cpu_wdata,
  output logic        cpu_stall,
  output logic [15:0] cpu_rdata,
  input  logic        dma_req,
  input  logic        dma_wen,
  input  logic [15:0] dma_addr,
  input  logic [15:0] dma_wdata,
  output logic        dma_ack,
  output logic [15:0] dma_rdata,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        mem_ren,
  output logic        mem_wen,
  input  logic [15:0] mem_rdata
`ifdef STUMP_ARB_STATS_EN
  ,
  output logic [15:0] cpu_grants,
  output logic [15:0] dma_grants
`endif
);

  localparam int CW = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
  localparam int SW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WAIT_STATES);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CPU_ACC = 2'd1,
    DMA_ACC = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [SW-1:0] starve_q, starve_d;
  logic [15:0]   mem_addr_q, mem_addr_d;
  logic [15:0]   mem_wdata_q, mem_wdata_d;
  logic          mem_ren_q, mem_ren_d;
  logic          mem_wen_q, mem_wen_d;
  logic          dma_ack_q, dma_ack_d;
  logic [15:0]   dma_rdata_q, dma_rdata_d;

  logic cnt_last;
  logic arb_point;
  logic cpu_done;
  logic dma_done;
  logic dma_elig;
  logic starve_full;
  logic grant_dma;
  logic grant_cpu;

  always_comb begin
    cnt_last    = (cnt_q == CNT_LAST);
    cpu_done    = (state_q == CPU_ACC) && cnt_last;
    dma_done    = (state_q == DMA_ACC) && cnt_last;
    arb_point   = (state_q == IDLE) || cnt_last;
    // A DMA request in its own completion cycle is already being served; the
    // requester only sees dma_ack one cycle later, so exclude it here too.
    dma_elig    = dma_req && !dma_ack_q && !dma_done;
    starve_full = (starve_q == STARVE_MAX);
    grant_dma   = arb_point && dma_elig && (!cpu_req || starve_full);
    grant_cpu   = arb_point && !grant_dma && cpu_req;
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = (state_q != IDLE) ? cnt_q + CW'(1) : cnt_q;
    starve_d    = starve_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_ren_d   = mem_ren_q;
    mem_wen_d   = mem_wen_q;
    dma_ack_d   = dma_done;
    dma_rdata_d = (dma_done && !mem_wen_q) ? mem_rdata : dma_rdata_q;

    if (grant_dma) begin
      state_d     = DMA_ACC;
      cnt_d       = '0;
      starve_d    = '0;
      mem_addr_d  = dma_addr;
      mem_wdata_d = dma_wdata;
      mem_wen_d   = dma_wen;
      mem_ren_d   = !dma_wen;
    end else if (grant_cpu) begin
      state_d     = CPU_ACC;
      cnt_d       = '0;
      mem_addr_d  = cpu_addr;
      mem_wdata_d = cpu_wdata;
      mem_wen_d   = cpu_wen;
      mem_ren_d   = !cpu_wen;
      if (dma_elig && !starve_full) begin
        starve_d = starve_q + SW'(1);
      end
    end else if (arb_point) begin
      state_d   = IDLE;
      cnt_d     = '0;
      mem_ren_d = 1'b0;
      mem_wen_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      starve_q    <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_ren_q   <= 1'b0;
      mem_wen_q   <= 1'b0;
      dma_ack_q   <= 1'b0;
      dma_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      starve_q    <= starve_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_ren_q   <= mem_ren_d;
      mem_wen_q   <= mem_wen_d;
      dma_ack_q   <= dma_ack_d;
      dma_rdata_q <= dma_rdata_d;
    end
  end

  assign cpu_stall = cpu_req && !cpu_done;
  assign cpu_rdata = mem_rdata;
  assign dma_ack   = dma_ack_q;
  assign dma_rdata = dma_rdata_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_ren   = mem_ren_q;
  assign mem_wen   = mem_wen_q;

`ifdef STUMP_ARB_STATS_EN
  logic [15:0] cpu_grants_q, cpu_grants_d;
  logic [15:0] dma_grants_q, dma_grants_d;

  always_comb begin
    cpu_grants_d = cpu_grants_q;
    dma_grants_d = dma_grants_q;
    if (grant_cpu && (cpu_grants_q != 16'hFFFF)) begin
      cpu_grants_d = cpu_grants_q + 16'd1;
    end
    if (grant_dma && (dma_grants_q != 16'hFFFF)) begin
      dma_grants_d = dma_grants_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cpu_grants_q <= '0;
      dma_grants_q <= '0;
    end else begin
      cpu_grants_q <= cpu_grants_d;
      dma_grants_q <= dma_grants_d;
    end
  end

  assign cpu_grants = cpu_grants_q;
  assign dma_grants = dma_grants_q;
`else
  // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_stump_mem_arbiter.sv
// Self-checking bench for stump_mem_arbiter: directed scenarios plus a read-data
// scoreboard fed at stimulus time and drained on CPU completion / dma_ack.
module tb_stump_mem_arbiter;

  localparam int WS = 1;
  localparam int SL = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cpu_req = 1'b0;
  logic        cpu_wen = 1'b0;
  logic [15:0] cpu_addr = '0;
  logic [15:0] cpu_wdata = '0;
  logic        cpu_stall;
  logic [15:0] cpu_rdata;
  logic        dma_req = 1'b0;
  logic        dma_wen = 1'b0;
  logic [15:0] dma_addr = '0;
  logic [15:0] dma_wdata = '0;
  logic        dma_ack;
  logic [15:0] dma_rdata;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_ren;
  logic        mem_wen;
  logic [15:0] mem_rdata;
`ifdef STUMP_ARB_STATS_EN
  logic [15:0] cpu_grants;
  logic [15:0] dma_grants;
`endif

  int errors = 0;
  int checks = 0;

  logic [15:0] cpu_exp_q[$];
  logic [15:0] dma_exp_q[$];
  logic [15:0] shadow[0:255];
  logic [15:0] last_dma_exp;
  logic [15:0] mon_cpu_exp;
  logic [15:0] mon_dma_exp;
  logic        preload = 1'b1;
  logic [15:0] mem[0:255];

  always #5 clk = ~clk;

  stump_mem_arbiter #(.WAIT_STATES(WS), .STARVE_LIMIT(SL)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_wen(cpu_wen), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_stall(cpu_stall), .cpu_rdata(cpu_rdata),
    .dma_req(dma_req), .dma_wen(dma_wen), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_ack(dma_ack), .dma_rdata(dma_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ren(mem_ren), .mem_wen(mem_wen),
    .mem_rdata(mem_rdata)
`ifdef STUMP_ARB_STATS_EN
    , .cpu_grants(cpu_grants), .dma_grants(dma_grants)
`endif
  );

  function automatic logic [15:0] init_val(input int i);
    return (i == 16) ? 16'hBEEF : (16'h5000 ^ 16'(i * 7));
  endfunction

  // Memory model: combinational read, write on clock edge.
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_val(i);
    end else if (mem_wen) begin
      mem[mem_addr[7:0]] <= mem_wdata;
    end
  end
  assign mem_rdata = mem[mem_addr[7:0]];

  // Scoreboard drain: CPU read completion and DMA ack.
  always @(negedge clk) begin
    if (rst && cpu_req && !cpu_wen && !cpu_stall) begin
      checks++;
      if (cpu_exp_q.size() == 0) begin
        errors++;
        $display("FAIL cpu_rdata: unexpected completion, got %h", cpu_rdata);
      end else begin
        mon_cpu_exp = cpu_exp_q.pop_front();
        if (cpu_rdata !== mon_cpu_exp) begin
          errors++;
          $display("FAIL cpu_rdata: got %h expected %h", cpu_rdata, mon_cpu_exp);
        end else begin
          $display("cpu read  addr=%h data=%h", cpu_addr, cpu_rdata);
        end
      end
    end
    if (rst && dma_ack) begin
      checks++;
      if (dma_exp_q.size() == 0) begin
        errors++;
        $display("FAIL dma_ack: unexpected ack, dma_rdata=%h", dma_rdata);
      end else begin
        mon_dma_exp = dma_exp_q.pop_front();
        if (dma_rdata !== mon_dma_exp) begin
          errors++;
          $display("FAIL dma_rdata: got %h expected %h", dma_rdata, mon_dma_exp);
        end else begin
          $display("dma ack   addr=%h rdata=%h", dma_addr, dma_rdata);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_access(input logic wen, input logic [15:0] addr, input logic [15:0] wdata,
                            output int cycles);
    cpu_req = 1'b1; cpu_wen = wen; cpu_addr = addr; cpu_wdata = wdata;
    if (wen) shadow[addr[7:0]] = wdata;
    else     cpu_exp_q.push_back(shadow[addr[7:0]]);
    #1;
    cycles = 0;
    while (cpu_stall && cycles < 30) begin
      tick();
      cycles++;
    end
    if (cpu_stall) begin
      errors++;
      $display("FAIL cpu_timeout: stall still %b after %0d cycles, required 0", cpu_stall, cycles);
    end
    @(negedge clk);
    #1;
    cpu_req = 1'b0; cpu_wen = 1'b0;
    tick();
  endtask

  task automatic dma_access(input logic wen, input logic [15:0] addr, input logic [15:0] wdata);
    int n;
    dma_req = 1'b1; dma_wen = wen; dma_addr = addr; dma_wdata = wdata;
    if (wen) shadow[addr[7:0]] = wdata;
    else     last_dma_exp = shadow[addr[7:0]];
    dma_exp_q.push_back(last_dma_exp);
    n = 0;
    do begin
      tick();
      n++;
    end while (!dma_ack && n < 30);
    checks++;
    if (!dma_ack) begin
      errors++;
      $display("FAIL dma_timeout: dma_ack=%b after %0d cycles, required 1", dma_ack, n);
    end
    dma_req = 1'b0; dma_wen = 1'b0;
    tick();
    checks++;
    if (dma_ack !== 1'b0) begin
      errors++;
      $display("FAIL dma_ack_pulse: dma_ack=%b, required 0", dma_ack);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    cpu_req = 1'b1;
    #2;
    tick();
    tick();
    checks++;
    if (cpu_stall !== 1'b1) begin errors++; $display("FAIL reset_stall_req: got %b required 1", cpu_stall); end
    checks++;
    if ({mem_ren, mem_wen, dma_ack} !== 3'b000) begin
      errors++; $display("FAIL reset_ctrl: ren/wen/ack=%b required 000", {mem_ren, mem_wen, dma_ack});
    end
    checks++;
    if ({mem_addr, mem_wdata, dma_rdata} !== 48'h0) begin
      errors++; $display("FAIL reset_data: addr=%h wdata=%h dma_rdata=%h required 0", mem_addr, mem_wdata, dma_rdata);
    end
    cpu_req = 1'b0;
    #1;
    checks++;
    if (cpu_stall !== 1'b0) begin errors++; $display("FAIL reset_stall_idle: got %b required 0", cpu_stall); end
    tick();
    rst = 1'b1;
    preload = 1'b0;
    last_dma_exp = '0;
    tick();
  endtask

  task automatic test_cpu_read();
    cpu_req = 1'b1; cpu_wen = 1'b0; cpu_addr = 16'h0010;
    cpu_exp_q.push_back(16'hBEEF);
    #1;
    checks++;
    if ({cpu_stall, mem_ren} !== 2'b10) begin errors++; $display("FAIL rd_c0: stall/ren=%b required 10", {cpu_stall, mem_ren}); end
    tick();
    checks++;
    if ({cpu_stall, mem_ren} !== 2'b11 || mem_addr !== 16'h0010) begin
      errors++; $display("FAIL rd_c1: stall/ren=%b addr=%h required 11 0010", {cpu_stall, mem_ren}, mem_addr);
    end
    tick();
    checks++;
    if ({cpu_stall, mem_ren} !== 2'b01) begin errors++; $display("FAIL rd_c2: stall/ren=%b required 01", {cpu_stall, mem_ren}); end
    @(negedge clk);
    #1;
    cpu_req = 1'b0;
    tick();
    checks++;
    if ({cpu_stall, mem_ren} !== 2'b00) begin errors++; $display("FAIL rd_c3: stall/ren=%b required 00", {cpu_stall, mem_ren}); end
  endtask

  task automatic test_dma_write();
    dma_req = 1'b1; dma_wen = 1'b1; dma_addr = 16'h0040; dma_wdata = 16'h1234;
    shadow[8'h40] = 16'h1234;
    dma_exp_q.push_back(last_dma_exp);
    #1;
    checks++;
    if ({mem_wen, dma_ack} !== 2'b00) begin errors++; $display("FAIL wr_c0: wen/ack=%b required 00", {mem_wen, dma_ack}); end
    tick();
    checks++;
    if ({mem_wen, mem_ren} !== 2'b10 || mem_addr !== 16'h0040 || mem_wdata !== 16'h1234) begin
      errors++; $display("FAIL wr_c1: wen/ren=%b addr=%h wdata=%h required 10 0040 1234", {mem_wen, mem_ren}, mem_addr, mem_wdata);
    end
    tick();
    checks++;
    if ({mem_wen, dma_ack} !== 2'b10) begin errors++; $display("FAIL wr_c2: wen/ack=%b required 10", {mem_wen, dma_ack}); end
    tick();
    checks++;
    if ({mem_wen, dma_ack} !== 2'b01) begin errors++; $display("FAIL wr_c3: wen/ack=%b required 01", {mem_wen, dma_ack}); end
    dma_req = 1'b0; dma_wen = 1'b0;
    tick();
    checks++;
    if (dma_ack !== 1'b0) begin errors++; $display("FAIL wr_c4: ack=%b required 0", dma_ack); end
  endtask

  task automatic test_starvation();
    cpu_req = 1'b1; cpu_wen = 1'b0; cpu_addr = 16'h0020;
    dma_req = 1'b1; dma_wen = 1'b0; dma_addr = 16'h0030;
    for (int i = 0; i < 4; i++) cpu_exp_q.push_back(shadow[8'h20]);
    last_dma_exp = shadow[8'h30];
    dma_exp_q.push_back(last_dma_exp);
    for (int c = 1; c <= 10; c++) begin
      tick();
      if (c == 1 || c == 3 || c == 5 || c == 9) begin
        checks++;
        if (mem_addr !== 16'h0020) begin errors++; $display("FAIL starve_cpu_grant c%0d: addr=%h required 0020", c, mem_addr); end
      end
      if (c == 7) begin
        checks++;
        if (mem_addr !== 16'h0030 || cpu_stall !== 1'b1) begin
          errors++; $display("FAIL starve_dma_grant: addr=%h stall=%b required 0030 1", mem_addr, cpu_stall);
        end
      end
      checks++;
      if (dma_ack !== (c == 9)) begin errors++; $display("FAIL starve_ack c%0d: ack=%b required %b", c, dma_ack, (c == 9)); end
      if (c == 9) dma_req = 1'b0;
    end
    @(negedge clk);
    #1;
    cpu_req = 1'b0;
    tick();
    checks++;
    if ({mem_ren, mem_wen} !== 2'b00) begin errors++; $display("FAIL starve_idle: ren/wen=%b required 00", {mem_ren, mem_wen}); end
  endtask

  task automatic test_simultaneous();
    cpu_req = 1'b1; cpu_wen = 1'b0; cpu_addr = 16'h0011;
    dma_req = 1'b1; dma_wen = 1'b0; dma_addr = 16'h0012;
    cpu_exp_q.push_back(shadow[8'h11]);
    last_dma_exp = shadow[8'h12];
    dma_exp_q.push_back(last_dma_exp);
    tick();
    checks++;
    if (mem_addr !== 16'h0011 || mem_ren !== 1'b1) begin
      errors++; $display("FAIL simul_cpu_first: addr=%h ren=%b required 0011 1", mem_addr, mem_ren);
    end
    tick();
    @(negedge clk);
    #1;
    cpu_req = 1'b0;
    tick();
    checks++;
    if (mem_addr !== 16'h0012) begin errors++; $display("FAIL simul_dma_next: addr=%h required 0012", mem_addr); end
    tick();
    tick();
    checks++;
    if (dma_ack !== 1'b1) begin errors++; $display("FAIL simul_ack: ack=%b required 1", dma_ack); end
    dma_req = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_dma();
    int acks;
    dma_req = 1'b1; dma_wen = 1'b0; dma_addr = 16'h0050;
    dma_exp_q.push_back(shadow[8'h50]);
    tick();
    checks++;
    if (mem_ren !== 1'b1) begin errors++; $display("FAIL abort_pre: ren=%b required 1", mem_ren); end
    rst = 1'b0;
    #1;
    checks++;
    if ({mem_ren, mem_wen, dma_ack} !== 3'b000) begin
      errors++; $display("FAIL abort_now: ren/wen/ack=%b required 000", {mem_ren, mem_wen, dma_ack});
    end
    tick();
    tick();
    checks++;
    if (dma_ack !== 1'b0) begin errors++; $display("FAIL abort_hold: ack=%b required 0", dma_ack); end
    rst = 1'b1;
    last_dma_exp = shadow[8'h50];
    acks = 0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (dma_ack) begin
        acks++;
        dma_req = 1'b0;
      end
    end
    checks++;
    if (acks != 1) begin errors++; $display("FAIL abort_reack: acks=%0d required 1", acks); end
  endtask

  task automatic test_back_to_back();
    int cyc;
    cpu_access(1'b1, 16'h0060, 16'hA5A5, cyc);
    checks++;
    if (cyc != WS + 1) begin errors++; $display("FAIL b2b_wr_cost: stall cycles=%0d required %0d", cyc, WS + 1); end
    cpu_access(1'b0, 16'h0060, 16'h0000, cyc);
    checks++;
    if (cyc != WS + 1) begin errors++; $display("FAIL b2b_rd_cost: stall cycles=%0d required %0d", cyc, WS + 1); end
    dma_access(1'b0, 16'h0060, 16'h0000);
    dma_access(1'b1, 16'h0061, 16'h0F0F);
    dma_access(1'b0, 16'h0061, 16'h0000);
    dma_access(1'b0, 16'h0040, 16'h0000);
  endtask

`ifdef STUMP_ARB_STATS_EN
  task automatic test_stats();
    int cyc;
    rst = 1'b0;
    tick();
    rst = 1'b1;
    last_dma_exp = '0;
    tick();
    for (int i = 0; i < 5; i++) cpu_access(1'b0, 16'(16'h0070 + i), 16'h0000, cyc);
    for (int i = 0; i < 2; i++) dma_access(1'b0, 16'(16'h0080 + i), 16'h0000);
    checks++;
    if (cpu_grants !== 16'd5 || dma_grants !== 16'd2) begin
      errors++; $display("FAIL stats: cpu_grants=%0d dma_grants=%0d required 5 2", cpu_grants, dma_grants);
    end
  endtask
`endif

  initial begin
    for (int i = 0; i < 256; i++) shadow[i] = init_val(i);
    last_dma_exp = '0;
    test_reset();
    test_cpu_read();
    test_dma_write();
    test_starvation();
    test_simultaneous();
    test_reset_mid_dma();
    test_back_to_back();
`ifdef STUMP_ARB_STATS_EN
    test_stats();
`endif
    tick();
    checks++;
    if (cpu_exp_q.size() != 0 || dma_exp_q.size() != 0) begin
      errors++; $display("FAIL scoreboard_drain: cpu left=%0d dma left=%0d required 0 0", cpu_exp_q.size(), dma_exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
